// File: rtl/matrix_scan_pwm_pkg.sv
// matrix_scan_pwm_pkg: shared types and sizing helpers
// for the LED matrix scan driver.
package matrix_scan_pwm_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    // Bits needed to count 0 .. n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One spare code above the pixel range keeps
    // out-of-range write addresses representable.
    function automatic int addr_w(input int npix);
        return $clog2(npix + 1);
    endfunction

endpackage

// File: rtl/matrix_scan_pwm_if.sv
// matrix_scan_pwm_if: host write/swap port plus
// matrix pin outputs of the scan driver.
interface matrix_scan_pwm_if
    import matrix_scan_pwm_pkg::*;
#(
    parameter int ROWS_N = 8,
    parameter int COLS_N = 8,
    parameter int BPP    = 2,
    parameter int AW     = addr_w(ROWS_N * COLS_N)
);
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [BPP-1:0]    wr_data;
    logic              swap;
    logic              swap_ack;
    logic              frame_start;
    logic [ROWS_N-1:0] rows;
    logic [COLS_N-1:0] columns;

    modport master (
        output wr_en, wr_addr, wr_data, swap,
        input  swap_ack, frame_start, rows, columns
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, swap,
        output swap_ack, frame_start, rows, columns
    );
endinterface

// File: rtl/matrix_scan_pwm_prescaler.sv
// matrix_scan_pwm_prescaler: one-cycle tick every DIV
// clocks; first tick DIV clocks after reset release.
module matrix_scan_pwm_prescaler
    import matrix_scan_pwm_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = cnt_w(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/matrix_scan_pwm.sv
// matrix_scan_pwm: double-buffered LED matrix scanner
// with per-row blanking and binary-threshold PWM.
module matrix_scan_pwm
    import matrix_scan_pwm_pkg::*;
#(
    parameter int ROWS_N = 8,
    parameter int COLS_N = 8,
    parameter int BPP    = 2,
    parameter int DIV    = 4,
    parameter int BLANK  = 1,
    parameter bit ROW_ON = 1'b1,
    parameter bit COL_ON = 1'b0
) (
    input logic              clk,
    input logic              rst,
    matrix_scan_pwm_if.slave bus
);
    localparam int NPIX  = ROWS_N * COLS_N;
    localparam int SLOTS = (1 << BPP) - 1;
    localparam int CMAX  = (BLANK > SLOTS) ? BLANK : SLOTS;
    localparam int AW    = addr_w(NPIX);
    localparam int PW    = cnt_w(NPIX);
    localparam int RW    = cnt_w(ROWS_N);
    localparam int CW    = cnt_w(CMAX);

    localparam logic [AW-1:0] NPIX_A  = AW'(NPIX);
    localparam logic [CW-1:0] BLANK_L = CW'(BLANK - 1);
    localparam logic [CW-1:0] SLOT_L  = CW'(SLOTS - 1);
    localparam logic [RW-1:0] ROW_L   = RW'(ROWS_N - 1);

    localparam logic [ROWS_N-1:0] ROWS_OFF =
        {ROWS_N{~ROW_ON}};
    localparam logic [COLS_N-1:0] COLS_OFF =
        {COLS_N{~COL_ON}};

    state_t            state, state_n;
    logic [RW-1:0]     row, row_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic              front;
    logic              pending;
    logic              tick;
    logic              wrap;
    logic              flip;
    logic [ROWS_N-1:0] rows_d;
    logic [COLS_N-1:0] cols_d;

    logic [BPP-1:0]    mem [2][NPIX];

    matrix_scan_pwm_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_comb begin
        state_n = state;
        row_n   = row;
        cnt_n   = cnt;
        wrap    = 1'b0;
        if (tick) begin
            unique case (state)
                ST_BLANK: begin
                    if (cnt == BLANK_L) begin
                        state_n = ST_DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt == SLOT_L) begin
                        state_n = ST_BLANK;
                        cnt_n   = '0;
                        wrap    = (row == ROW_L);
                        row_n   = wrap ? '0 : row + RW'(1);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign flip = wrap & pending;

    // Outputs are decoded from the next scan position so they
    // land together with the state change on the tick edge.
    always_comb begin
        rows_d = ROWS_OFF;
        cols_d = COLS_OFF;
        if (state_n == ST_DRIVE) begin
            rows_d[row_n] = ROW_ON;
            for (int c = 0; c < COLS_N; c++) begin
                if (int'(mem[front][PW'(int'(row_n) * COLS_N + c)])
                    > int'(cnt_n)) begin
                    cols_d[c] = COL_ON;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_BLANK;
            row             <= '0;
            cnt             <= '0;
            front           <= 1'b0;
            pending         <= 1'b0;
            bus.rows        <= ROWS_OFF;
            bus.columns     <= COLS_OFF;
            bus.swap_ack    <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            state           <= state_n;
            row             <= row_n;
            cnt             <= cnt_n;
            if (flip) front <= ~front;
            pending         <= flip ? bus.swap
                                    : (pending | bus.swap);
            bus.rows        <= rows_d;
            bus.columns     <= cols_d;
            bus.swap_ack    <= flip;
            bus.frame_start <= wrap;
        end
    end

    // Writes use the pre-flip back bank, so a write in the
    // flip cycle ends up in the new front bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < NPIX; p++) begin
                    mem[b][p] <= '0;
                end
            end
        end else if (bus.wr_en && (bus.wr_addr < NPIX_A)) begin
            mem[~front][bus.wr_addr[PW-1:0]] <= bus.wr_data;
        end
    end
endmodule

// File: tb/tb_matrix_scan_pwm.sv
// tb_matrix_scan_pwm: randomized and directed checks of the
// scan driver against a position-based frame model.
module tb_matrix_scan_pwm;
    localparam int R     = 8;
    localparam int C     = 8;
    localparam int BPP   = 2;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int NP    = R * C;
    localparam int P     = BLANK + (1 << BPP) - 1;
    localparam int FT    = R * P;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_scan_pwm_if #(
        .ROWS_N (R),
        .COLS_N (C),
        .BPP    (BPP)
    ) bus ();

    matrix_scan_pwm #(
        .ROWS_N (R),
        .COLS_N (C),
        .BPP    (BPP),
        .DIV    (DIV),
        .BLANK  (BLANK),
        .ROW_ON (1'b1),
        .COL_ON (1'b0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    // Model: scan position derived from clocks since reset.
    bit         started = 0;
    int         k;
    int         fr [NP];
    int         bk [NP];
    bit         pend;
    logic [7:0] e_rows, e_cols;
    logic       e_fs, e_ack;
    int         m, pos, r_i, q_i, tmp;
    bit         tk, bnd, ack;

    // Monitor trackers.
    int         cyc = 0;
    int         ack_n = 0;
    int         last_ack = 0;
    int         ack_gap = 0;
    int         last_fs = 0;
    bit         fs_v, nz_v, gap_v;
    int         gap;
    logic [7:0] last_nz, prev;

    always @(posedge clk) begin
        if (rst) begin
            started = 1;
            k = 0;
            for (int i = 0; i < NP; i++) begin
                fr[i] = 0;
                bk[i] = 0;
            end
            pend   = 0;
            e_rows = 8'h00;
            e_cols = 8'hFF;
            e_fs   = 0;
            e_ack  = 0;
            fs_v   = 0;
            nz_v   = 0;
            gap_v  = 0;
            prev   = 8'h00;
        end else if (started) begin
            k++;
            tk  = (k > DIV) && ((k - 1) % DIV == 0);
            m   = (k <= DIV) ? 0 : (k - 1) / DIV;
            bnd = tk && (m % FT == 0);
            if (bus.wr_en && int'(bus.wr_addr) < NP)
                bk[int'(bus.wr_addr)] = int'(bus.wr_data);
            ack = bnd && pend;
            if (ack) begin
                for (int i = 0; i < NP; i++) begin
                    tmp   = fr[i];
                    fr[i] = bk[i];
                    bk[i] = tmp;
                end
            end
            pend   = ack ? bus.swap : (pend | bus.swap);
            e_fs   = bnd;
            e_ack  = ack;
            pos    = m % FT;
            r_i    = pos / P;
            q_i    = pos % P;
            e_rows = 8'h00;
            e_cols = 8'hFF;
            if (q_i >= BLANK) begin
                e_rows[r_i] = 1'b1;
                for (int c = 0; c < C; c++)
                    if (fr[r_i * C + c] > q_i - BLANK)
                        e_cols[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            cyc++;
            chk("rows", bus.rows, e_rows);
            chk("columns", bus.columns, e_cols);
            chk("swap_ack", bus.swap_ack, e_ack);
            chk("frame_start", bus.frame_start, e_fs);
            chk("rows_onehot",
                32'($countones(bus.rows) <= 1), 1);
            if (bus.frame_start === 1'b1) begin
                if (fs_v) chk("fs_spacing", cyc - last_fs, 128);
                fs_v    = 1;
                last_fs = cyc;
            end
            if (bus.swap_ack === 1'b1) begin
                ack_n++;
                ack_gap  = cyc - last_ack;
                last_ack = cyc;
            end
            if (bus.rows != 8'h00 && prev == 8'h00) begin
                if (nz_v)
                    chk("row_step", bus.rows,
                        (last_nz == 8'h80) ? 8'h01 : last_nz << 1);
                if (gap_v) chk("blank_gap", gap, 4);
                nz_v    = 1;
                last_nz = bus.rows;
                gap_v   = 0;
            end else if (bus.rows == 8'h00) begin
                if (prev != 8'h00) begin
                    gap_v = 1;
                    gap   = 1;
                end else begin
                    gap++;
                end
            end
            prev = bus.rows;
        end
    end

    task automatic wait_rows(input logic [7:0] v,
                             input string nm);
        int i = 0;
        while (bus.rows !== v && i < 600) begin
            @(negedge clk);
            i++;
        end
        if (bus.rows !== v) chk(nm, bus.rows, v);
    endtask

    task automatic wait_fs(input string nm);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (bus.frame_start !== 1'b1 && i < 300);
        if (bus.frame_start !== 1'b1) chk(nm, 0, 1);
    endtask

    task automatic wait_ack(input string nm);
        int i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (bus.swap_ack !== 1'b1 && i < 300);
        if (bus.swap_ack !== 1'b1) chk(nm, 0, 1);
    endtask

    task automatic wr(input int a, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 7'(a);
        bus.wr_data = 2'(d);
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_swap();
        bus.swap = 1'b1;
        @(negedge clk);
        bus.swap = 1'b0;
    endtask

    int a0, l0, l1, l2, dl, lit;

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.swap    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t1_rows", bus.rows, 8'h00);
        chk("t1_cols", bus.columns, 8'hFF);
        chk("t1_ack", bus.swap_ack, 0);

        wr(0, 3);
        wr(1, 1);
        wr(2, 0);
        pulse_swap();
        wait_ack("t2_ack_timeout");
        wait_rows(8'h01, "t2_row0_timeout");
        l0 = 0; l1 = 0; l2 = 0; dl = 0;
        while (bus.rows === 8'h01 && dl < 40) begin
            dl++;
            if (!bus.columns[0]) l0++;
            if (!bus.columns[1]) l1++;
            if (!bus.columns[2]) l2++;
            @(negedge clk);
        end
        chk("t2_drive_len", dl, 12);
        chk("t2_col0_lit", l0, 12);
        chk("t2_col1_lit", l1, 4);
        chk("t2_col2_lit", l2, 0);

        wait_fs("t3_fs_timeout");
        wait_fs("t3_fs_timeout");

        wait_fs("t4_fs_timeout");
        a0 = ack_n;
        wait_rows(8'h08, "t4_row3_timeout");
        pulse_swap();
        wait_rows(8'h20, "t4_row5_timeout");
        pulse_swap();
        wait_fs("t4_fs_timeout");
        repeat (2) @(negedge clk);
        chk("t4_one_ack", ack_n - a0, 1);
        wait_fs("t4_fs_timeout");
        repeat (2) @(negedge clk);
        chk("t4_no_extra", ack_n - a0, 1);

        wait_fs("t5_fs_timeout");
        bus.swap = 1'b1;
        wr(64, 3);
        a0 = ack_n;
        wait_fs("t5_fs_timeout");
        wait_fs("t5_fs_timeout");
        bus.swap = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_two_acks", ack_n - a0, 2);
        chk("t5_ack_gap", ack_gap, 128);

        for (int i = 0; i < 2500; i++) begin
            bus.wr_en   = 1'($urandom_range(0, 1));
            bus.wr_addr = 7'($urandom_range(0, 71));
            bus.wr_data = 2'($urandom_range(0, 3));
            bus.swap    = ($urandom_range(0, 63) == 0);
            @(negedge clk);
        end
        bus.wr_en = 1'b0;
        bus.swap  = 1'b0;

        wait_fs("t6_fs_timeout");
        wait_rows(8'h10, "t6_row4_timeout");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rows", bus.rows, 8'h00);
        chk("t6_cols", bus.columns, 8'hFF);
        chk("t6_ack", bus.swap_ack, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse_swap();
        wait_ack("t6_ack_timeout");
        lit = 0;
        repeat (130) begin
            @(negedge clk);
            if (bus.columns !== 8'hFF) lit++;
        end
        chk("t6_all_zero", lit, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
